// File: rtl/mult_pipe_ctrl.sv
// Pipeline controller for a pipelined array multiplier: operand capture, per-rank load enables, output register.
// Latency: STAGES+1 edges from accept to out_valid (4 cycles at STAGES=3); sustains 1 op/cycle.
// Backpressure: stalls ripple back only through full positions; in_ready is combinational on out_ready (no skid).
module mult_pipe_ctrl #(
    parameter int WIDTH  = 10,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_a,
    input  logic [WIDTH-1:0]             in_b,
    input  logic [TAG_W-1:0]             in_tag,
    output logic [WIDTH-1:0]             op_a,
    output logic [WIDTH-1:0]             op_b,
    output logic [STAGES-1:0]            stage_en,
    output logic [STAGES-1:0]            stage_vld,
    input  logic [2*WIDTH-1:0]           dp_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*WIDTH-1:0]           out_result,
    output logic [TAG_W-1:0]             out_tag,
    output logic [$clog2(STAGES+3)-1:0]  inflight
);

    localparam int CNT_W = $clog2(STAGES+3);

    // Index 0 is the operand register, 1..STAGES are the datapath ranks.
    logic [STAGES:0]            vld;
    logic [STAGES:0][TAG_W-1:0] tag;
    logic [STAGES:0]            adv;
    logic                       adv_o;
    logic                       accept;

    assign adv_o = !out_valid || out_ready;

    // A position can advance unless it and every position downstream of it is full and the output is stalled.
    for (genvar k = 0; k <= STAGES; k++) begin : g_adv
        assign adv[k] = adv_o || !(&vld[STAGES:k]);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign stage_en[k]  = vld[k] && adv[k+1] && !flush;
        assign stage_vld[k] = vld[k+1];
    end

    assign in_ready = adv[0] && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld        <= '0;
            tag        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            vld       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (adv[0]) begin
                vld[0] <= in_valid;
            end
            if (accept) begin
                op_a   <= in_a;
                op_b   <= in_b;
                tag[0] <= in_tag;
            end
            for (int k = 1; k <= STAGES; k++) begin
                if (adv[k]) begin
                    vld[k] <= vld[k-1];
                end
                if (stage_en[k-1]) begin
                    tag[k] <= tag[k-1];
                end
            end
            if (adv_o) begin
                out_valid <= vld[STAGES];
                if (vld[STAGES]) begin
                    out_result <= dp_result;
                    out_tag    <= tag[STAGES];
                end
            end
        end
    end

    always_comb begin
        inflight = CNT_W'(out_valid);
        for (int k = 0; k <= STAGES; k++) begin
            inflight = inflight + CNT_W'(vld[k]);
        end
    end

    // A stalled result must not change under the consumer.
    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=> ($stable(out_result) && $stable(out_tag)));

endmodule

// File: tb/tb_mult_pipe_ctrl.sv
// Bench for mult_pipe_ctrl: enabled-register datapath model, operation-level queue model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_mult_pipe_ctrl;

    localparam int WIDTH  = 10;
    localparam int STAGES = 3;
    localparam int TAG_W  = 4;
    localparam int PO     = STAGES + 1;
    localparam int CNT_W  = $clog2(STAGES+3);

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [TAG_W-1:0]     in_tag;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [STAGES-1:0]    stage_en;
    logic [STAGES-1:0]    stage_vld;
    logic [2*WIDTH-1:0]   dp_result;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_result;
    logic [TAG_W-1:0]     out_tag;
    logic [CNT_W-1:0]     inflight;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    mult_pipe_ctrl #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .op_a(op_a), .op_b(op_b),
        .stage_en(stage_en), .stage_vld(stage_vld),
        .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .inflight(inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*WIDTH-1:0] prod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (2*WIDTH)'(a) * (2*WIDTH)'(b);
    endfunction

    // Datapath stand-in: multiply into rank 0, then shift along the enabled ranks.
    logic [2*WIDTH-1:0] dp_rank [STAGES];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) dp_rank[k] <= '0;
        end else begin
            if (stage_en[0]) dp_rank[0] <= prod(op_a, op_b);
            for (int k = 1; k < STAGES; k++) begin
                if (stage_en[k]) dp_rank[k] <= dp_rank[k-1];
            end
        end
    end
    assign dp_result = dp_rank[STAGES-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Operation-level model: each in-flight op knows its position (0 = operand regs, PO = output reg),
    // oldest first. An op moves forward if the slot ahead is empty or its occupant moves too.
    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
        int               pos;
    } op_t;

    op_t                mq[$];
    bit                 mv[16];
    bit                 e_in_ready;
    logic [2*WIDTH-1:0] m_last_res;
    logic [TAG_W-1:0]   m_last_tag;
    logic [WIDTH-1:0]   m_op_a;
    logic [WIDTH-1:0]   m_op_b;

    logic [2*WIDTH-1:0] got_res[$];
    logic [TAG_W-1:0]   got_tag[$];
    int                 got_cyc[$];

    task automatic compute();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].pos == PO)  mv[i] = out_ready;
            else if (i == 0)      mv[i] = 1'b1;
            else                  mv[i] = !((mq[i-1].pos == mq[i].pos + 1) && !mv[i-1]);
        end
        e_in_ready = !flush && (mq.size() == 0 || mq[mq.size()-1].pos > 0 || mv[mq.size()-1]);
    endtask

    initial begin : model_upd
        op_t o;
        bit  pop;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_last_res = '0;
                m_last_tag = '0;
                m_op_a     = '0;
                m_op_b     = '0;
            end else begin
                compute();
                if (flush) begin
                    mq.delete();
                end else begin
                    pop = mq.size() > 0 && mq[0].pos == PO && mv[0];
                    for (int i = 0; i < mq.size(); i++) begin
                        if (mv[i] && mq[i].pos != PO) begin
                            mq[i].pos = mq[i].pos + 1;
                            if (mq[i].pos == PO) begin
                                m_last_res = prod(mq[i].a, mq[i].b);
                                m_last_tag = mq[i].tag;
                            end
                        end
                    end
                    if (pop) mq.delete(0);
                    if (in_valid && e_in_ready) begin
                        o.a = in_a; o.b = in_b; o.tag = in_tag; o.pos = 0;
                        mq.push_back(o);
                        m_op_a = in_a;
                        m_op_b = in_b;
                    end
                end
            end
        end
    end

    initial begin : monitor
        logic [STAGES-1:0] e_en;
        logic [STAGES-1:0] e_sv;
        bit                exp_ov;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                compute();
                e_en = '0;
                e_sv = '0;
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].pos >= 1 && mq[i].pos <= STAGES) e_sv[mq[i].pos-1] = 1'b1;
                    if (!flush && mq[i].pos < STAGES && mv[i])  e_en[mq[i].pos]   = 1'b1;
                end
                exp_ov = mq.size() > 0 && mq[0].pos == PO;
                check("m_out_valid", 64'(out_valid), 64'(exp_ov));
                if (exp_ov) begin
                    check("m_out_result", 64'(out_result), 64'(prod(mq[0].a, mq[0].b)));
                    check("m_out_tag", 64'(out_tag), 64'(mq[0].tag));
                end else begin
                    check("m_result_hold", 64'(out_result), 64'(m_last_res));
                    check("m_tag_hold", 64'(out_tag), 64'(m_last_tag));
                end
                check("m_in_ready", 64'(in_ready), 64'(e_in_ready));
                check("m_inflight", 64'(inflight), 64'(mq.size()));
                check("m_stage_vld", 64'(stage_vld), 64'(e_sv));
                check("m_stage_en", 64'(stage_en), 64'(e_en));
                check("m_op_a", 64'(op_a), 64'(m_op_a));
                check("m_op_b", 64'(op_b), 64'(m_op_b));
                if (out_valid && out_ready) begin
                    got_res.push_back(out_result);
                    got_tag.push_back(out_tag);
                    got_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic clear_got();
        got_res.delete();
        got_tag.delete();
        got_cyc.delete();
    endtask

    // Drive one cycle's inputs at posedge+1, report whether the op was taken, return at the next posedge+1.
    task automatic step(input bit v, input int a, input int b, input int t,
                        input bit ordy, input bit fl, output bit acc);
        in_valid  = v;
        in_a      = WIDTH'(a);
        in_b      = WIDTH'(b);
        in_tag    = TAG_W'(t);
        out_ready = ordy;
        flush     = fl;
        #1;
        acc = v && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int a, input int b, input int t, input logic [63:0] exp_res, input string nm);
        bit acc;
        bit dummy;
        int lat;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) step(1'b1, a, b, t, 1'b1, 1'b0, acc);
        check({nm, "_accept"}, 64'(acc), 64'(1));
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            step(1'b0, 0, 0, 0, 1'b1, 1'b0, dummy);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        check({nm, "_latency"}, 64'(lat), 64'(4));
        check({nm, "_result"}, 64'(out_result), exp_res);
        check({nm, "_tag"}, 64'(out_tag), 64'(t));
        step(1'b0, 0, 0, 0, 1'b1, 1'b0, dummy);
        check({nm, "_pulse"}, 64'(out_valid), 64'(0));
    endtask

    initial begin : stim
        bit acc;
        int n;
        int guard;
        int a;
        int b;
        logic [2*WIDTH-1:0] s_res[$];
        logic [TAG_W-1:0]   s_tag[$];

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_inflight", 64'(inflight), 64'(0));
        check("rst_stage_en", 64'(stage_en), 64'(0));
        check("rst_op_a", 64'(op_a), 64'(0));
        check("rst_out_result", 64'(out_result), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Single operation.
        do_op(7, 9, 3, 64'd63, "single");

        // Streaming, 8 back-to-back.
        clear_got();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i, i + 1, i, 1'b1, 1'b0, acc);
            check("stream_in_ready", 64'(acc), 64'(1));
        end
        for (int i = 0; i < 8; i++) step(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);
        check("stream_count", 64'(got_res.size()), 64'(8));
        for (int i = 0; i < got_res.size() && i < 8; i++) begin
            check("stream_result", 64'(got_res[i]), 64'(i * (i + 1)));
            check("stream_tag", 64'(got_tag[i]), 64'(i));
            check("stream_back_to_back", 64'(got_cyc[i] - got_cyc[0]), 64'(i));
        end

        // Backpressure: output held off while ops keep arriving.
        clear_got();
        n = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, n + 2, 3 * n + 1, n + 8, 1'b0, 1'b0, acc);
            if (acc) n++;
        end
        check("bp_accepted", 64'(n), 64'(5));
        check("bp_inflight", 64'(inflight), 64'(5));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        check("bp_out_result", 64'(out_result), 64'(2));
        check("bp_out_tag", 64'(out_tag), 64'(8));
        step(1'b1, 50, 50, 1, 1'b0, 1'b0, acc);
        step(1'b1, 50, 50, 1, 1'b0, 1'b0, acc);
        check("bp_result_stable", 64'(out_result), 64'(2));
        for (int c = 0; c < 10; c++) step(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);
        check("bp_drain_count", 64'(got_res.size()), 64'(5));
        for (int i = 0; i < got_res.size() && i < 5; i++) begin
            check("bp_drain_result", 64'(got_res[i]), 64'((i + 2) * (3 * i + 1)));
            check("bp_drain_tag", 64'(got_tag[i]), 64'(i + 8));
        end

        // Operand extremes.
        do_op(1023, 1023, 5, 64'd1046529, "max_x_max");
        do_op(0, 1023, 6, 64'd0, "zero_x_max");

        // Random out_ready and in_valid over 1000 operations.
        clear_got();
        n = 0;
        guard = 0;
        while (n < 1000 && guard < 20000) begin
            a = int'($urandom_range(0, 1023));
            b = int'($urandom_range(0, 1023));
            step($urandom_range(0, 3) != 0, a, b, n % 16, 1'($urandom_range(0, 1)), 1'b0, acc);
            if (acc) begin
                s_res.push_back(prod(WIDTH'(a), WIDTH'(b)));
                s_tag.push_back(TAG_W'(n % 16));
                n++;
            end
            guard++;
        end
        check("rand_all_sent", 64'(n), 64'(1000));
        for (int c = 0; c < 20; c++) step(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);
        check("rand_count", 64'(got_res.size()), 64'(s_res.size()));
        for (int i = 0; i < got_res.size() && i < s_res.size(); i++) begin
            check("rand_result", 64'(got_res[i]), 64'(s_res[i]));
            check("rand_tag", 64'(got_tag[i]), 64'(s_tag[i]));
        end

        // Flush with three ops in flight.
        clear_got();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 10 + i, 3, i + 1, 1'b1, 1'b0, acc);
            check("flush_fill_accept", 64'(acc), 64'(1));
        end
        in_valid = 1'b1; in_a = 10'd99; in_b = 10'd99; in_tag = 4'd15;
        out_ready = 1'b1; flush = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'(0));
        check("flush_stage_en", 64'(stage_en), 64'(0));
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_inflight", 64'(inflight), 64'(0));
        check("flush_stage_vld", 64'(stage_vld), 64'(0));
        check("flush_out_valid", 64'(out_valid), 64'(0));
        for (int c = 0; c < 6; c++) step(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);
        check("flush_no_stale", 64'(got_res.size()), 64'(0));
        do_op(12, 13, 9, 64'd156, "post_flush");

        // Asynchronous reset mid-stream, between clock edges.
        for (int i = 0; i < 3; i++) step(1'b1, 31, 2 + i, i, 1'b1, 1'b0, acc);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_inflight", 64'(inflight), 64'(0));
        check("arst_stage_vld", 64'(stage_vld), 64'(0));
        check("arst_stage_en", 64'(stage_en), 64'(0));
        check("arst_op_a", 64'(op_a), 64'(0));
        check("arst_op_b", 64'(op_b), 64'(0));
        check("arst_out_result", 64'(out_result), 64'(0));
        check("arst_out_tag", 64'(out_tag), 64'(0));
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        do_op(21, 2, 4, 64'd42, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mult_pipe_ctrl.md
Name: mult_pipe_ctrl

Overview:
Pipeline controller for the pipelined array multiplier: partial-product generation, the half/full-adder reduction stages and the final adder.
- Accepts operand pairs on a valid/ready handshake and registers them as the datapath operands.
- Issues per-stage load enables to the datapath pipeline registers and tracks a valid bit and tag per stage.
- Captures the datapath product into an output register with backpressure, so the datapath itself stays purely combinational plus enabled registers.

Parameters:
WIDTH, 10, operand width; product is 2*WIDTH bits
STAGES, 3, number of datapath pipeline register ranks between operand regs and output reg (>=1)
TAG_W, 4, width of the user tag carried alongside each operation

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush
in_valid  input  1  operand pair offered
in_ready  output  1  controller accepts this cycle
in_a  input  WIDTH  multiplicand (unsigned)
in_b  input  WIDTH  multiplier (unsigned)
in_tag  input  TAG_W  tag returned with result
op_a  output  WIDTH  registered multiplicand to datapath
op_b  output  WIDTH  registered multiplier to datapath
stage_en  output  STAGES  load enable for datapath register rank k (0 = rank after operand regs)
stage_vld  output  STAGES  valid bit of each datapath rank (debug/observability)
dp_result  input  2*WIDTH  product from final datapath rank
out_valid  output  1  result available
out_ready  input  1  consumer accepts
out_result  output  2*WIDTH  registered product
out_tag  output  TAG_W  tag of out_result
inflight  output  $clog2(STAGES+3)  number of occupied positions

Behaviour:
- Positions: P0 = operand regs, P1..PSTAGES = datapath ranks, PO = output reg. Each position has a valid bit and a tag register.
- Advance terms (combinational, from PO backwards):
  - adv_O = !out_valid || out_ready
  - adv_k = !vld_k || adv_(k+1)
  - adv_STAGES+1 ≡ adv_O
- in_ready = adv_0 && !flush. Accept = in_valid && in_ready: loads op_a, op_b and tag0, and sets vld0.
- When adv_0 is true and there is no accept, vld0 clears; op_a/op_b hold their values.
- stage_en[k] = vld_k && adv_(k+1). On stage_en[k], vld_(k+1) and tag_(k+1) load from position k. If adv_(k+1) holds and vld_k is 0, vld_(k+1) clears.
- PO loads out_result = dp_result and out_tag = tag_STAGES when vld_STAGES && adv_O. out_valid follows the same rule as the other positions.
- Latency: an operation accepted at edge E has out_valid=1 in the cycle after edge E+STAGES+1, i.e. 4 cycles for STAGES=3.
- Throughput: 1 op/cycle when out_ready=1 continuously. No bubbles are inserted.
- Backpressure:
  - out_ready=0 with out_valid=1 holds out_result/out_tag stable.
  - Upstream positions keep filling until every position is valid, then in_ready=0.
  - Capacity is STAGES+2 operations.
  - in_ready depends combinationally on out_ready (no skid). This is a decided property.
- inflight = popcount of the valid bits of P0..PSTAGES and PO. Accept together with an output handshake in the same cycle leaves it unchanged.
- Flush (synchronous, highest priority):
  - Next edge clears all valid bits, including out_valid; inflight becomes 0.
  - in_ready=0 and stage_en=0 during the flush cycle. Data and tag registers hold.
- Reset (asynchronous, any time including mid-operation):
  - All valid bits=0, op_a=op_b=0, out_result=0, out_tag=0, all tags=0, inflight=0.
  - stage_en=0. in_ready=1 once rst_n is high and flush is 0.
- Operands are unsigned; the controller performs no arithmetic on data. Product correctness belongs to the datapath. The controller guarantees that tag and product alignment is preserved under any stall pattern.

Test Plan:
- Bench datapath model: STAGES-deep enabled register chain computing op_a*op_b.
- Single op: in_a=7, in_b=9, tag=3, out_ready=1 -> out_valid high exactly 4 cycles after accept, out_result=63, out_tag=3, single-cycle pulse.
- Streaming: 8 back-to-back ops (a=i, b=i+1, tag=i), out_ready=1 -> in_ready stays 1, results 0,2,6,...,56 on 8 consecutive cycles in tag order.
- Backpressure: stream ops with out_ready=0 -> exactly 5 accepted, then in_ready=0 and inflight=5. out_result stays stable. Releasing out_ready drains all 5 in order with no loss or duplication.
- Extremes: a=b=1023 -> 1046529. a=0, b=1023 -> 0. Random out_ready toggling over 1000 ops -> scoreboard match on product and tag.
- Flush: with 3 ops in flight, pulse flush 1 cycle -> next cycle all valids 0, inflight=0, no stale out_valid. A new op afterwards completes with latency 4.
- Reset: assert rst_n=0 mid-stream, between clock edges -> outputs clear immediately without a clock edge. After release, in_ready=1 and the first op completes correctly.
